// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file with pending-write scoreboard.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// Per-register pending-write bits: issue sets, writeback clears, set wins on collision.
module regfile_scoreboard_bits import regfile_pkg::*; #(
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          issue_valid,
   input  logic [AW-1:0] issue_rd,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [AW-1:0] rs1_addr,
   input  logic [AW-1:0] rs2_addr,
   output logic          rs1_busy,
   output logic          rs2_busy
);

   logic [NREGS-1:0] busy;

   // Bit 0 is only ever written by reset, so x0 never reports a pending write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= '0;
      end else if (en) begin
         for (int r = 1; r < NREGS; r++) begin
            if (issue_valid && issue_rd == AW'(r))
               busy[r] <= 1'b1;
            else if (wb_en && wb_addr == AW'(r))
               busy[r] <= 1'b0;
         end
      end
   end

   assign rs1_busy = en & busy[rs1_addr];
   assign rs2_busy = en & busy[rs2_addr];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with post-reset clear sweep and pending-write scoreboard.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard import regfile_pkg::*; #(
   parameter  int XLEN  = XLEN_DEF,
   parameter  int NREGS = NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            ready,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] rf [NREGS];
   rf_state_t       state;
   logic [AW-1:0]   clr_cnt;
   logic            sb_rs1_busy;
   logic            sb_rs2_busy;
   logic            wr_run;

   assign wr_run = ready && wb_en && (wb_addr != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else if (state == CLEAR) begin
         clr_cnt <= clr_cnt + AW'(1);
         if (clr_cnt == AW'(NREGS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
         end
      end
   end

   // Storage has no reset term: contents survive reset and are zeroed by the sweep.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == CLEAR)
            rf[clr_cnt] <= '0;
         else if (wr_run)
            rf[wb_addr] <= wb_data;
      end
   end

   regfile_scoreboard_bits #(
      .NREGS (NREGS)
   ) u_bits (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (ready),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (sb_rs1_busy),
      .rs2_busy    (sb_rs2_busy)
   );

   always_comb begin
      rs1_data = '0;
      rs1_busy = sb_rs1_busy;
      if (ready && rs1_addr != '0)
         rs1_data = rf[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle issue to this register is a new producer, so busy is kept.
      if (ready && wb_en && wb_addr == rs1_addr && rs1_addr != '0) begin
         rs1_data = wb_data;
         if (!(issue_valid && issue_rd == rs1_addr))
            rs1_busy = 1'b0;
      end
`endif
   end

   always_comb begin
      rs2_data = '0;
      rs2_busy = sb_rs2_busy;
      if (ready && rs2_addr != '0)
         rs2_data = rf[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (ready && wb_en && wb_addr == rs2_addr && rs2_addr != '0) begin
         rs2_data = wb_data;
         if (!(issue_valid && issue_rd == rs2_addr))
            rs2_busy = 1'b0;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed table, hand sequences, random traffic vs. array model.
module tb_regfile_scoreboard;

   localparam int XL  = 32;
   localparam int NR  = 32;
   localparam int PXL = 64;
   localparam int PNR = 16;
`ifdef REGFILE_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ready;
   logic [4:0]    rs1_addr, rs2_addr, issue_rd, wb_addr;
   logic [XL-1:0] rs1_data, rs2_data, wb_data;
   logic          rs1_busy, rs2_busy, issue_valid, wb_en;

   logic           p_ready;
   logic [3:0]     p_rs1_addr, p_rs2_addr, p_issue_rd, p_wb_addr;
   logic [PXL-1:0] p_rs1_data, p_rs2_data, p_wb_data;
   logic           p_rs1_busy, p_rs2_busy, p_issue_valid, p_wb_en;

   regfile_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .ready(ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   regfile_scoreboard #(.XLEN(PXL), .NREGS(PNR)) dut_p (
      .clk(clk), .rst_n(rst_n), .ready(p_ready),
      .rs1_addr(p_rs1_addr), .rs2_addr(p_rs2_addr),
      .rs1_data(p_rs1_data), .rs2_data(p_rs2_data),
      .rs1_busy(p_rs1_busy), .rs2_busy(p_rs2_busy),
      .issue_valid(p_issue_valid), .issue_rd(p_issue_rd),
      .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data)
   );

   int errors = 0;
   int checks = 0;

   // Architectural model of the 32-entry instance.
   logic [XL-1:0] m_rf [NR];
   bit            m_busy [NR];
   bit            m_ready;
   int            m_cnt;

   typedef struct {
      logic       we;
      logic [4:0] wa;
      logic [31:0] wd;
      logic       iv;
      logic [4:0] ir;
      logic [4:0] a1, a2;
      logic [31:0] d1;
      logic       b1;
      logic [31:0] d2;
      logic       b2;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd,
                               input int iv, input int ir, input int a1, input int a2,
                               input logic [31:0] d1, input int b1,
                               input logic [31:0] d2, input int b2);
      vec_t v;
      v.we = (we != 0); v.wa = 5'(wa); v.wd = wd;
      v.iv = (iv != 0); v.ir = 5'(ir);
      v.a1 = 5'(a1); v.a2 = 5'(a2);
      v.d1 = d1; v.b1 = (b1 != 0); v.d2 = d2; v.b2 = (b2 != 0);
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [XL-1:0] exp_data(input logic [4:0] a);
      if (!m_ready || a == 5'd0) return '0;
      if (BP && wb_en && wb_addr == a) return wb_data;
      return m_rf[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (!m_ready) return 1'b0;
      if (BP && wb_en && wb_addr == a && a != 5'd0 && !(issue_valid && issue_rd == a))
         return 1'b0;
      return m_busy[a];
   endfunction

   task automatic check_all(input string tag);
      chk({tag, " ready"},    64'(ready),    64'(m_ready));
      chk({tag, " rs1_data"}, 64'(rs1_data), 64'(exp_data(rs1_addr)));
      chk({tag, " rs1_busy"}, 64'(rs1_busy), 64'(exp_busy(rs1_addr)));
      chk({tag, " rs2_data"}, 64'(rs2_data), 64'(exp_data(rs2_addr)));
      chk({tag, " rs2_busy"}, 64'(rs2_busy), 64'(exp_busy(rs2_addr)));
   endtask

   // Commit the currently driven inputs to the model, then step to the next negedge.
   task automatic cycle();
      if (!rst_n) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else if (!m_ready) begin
         m_cnt++;
         if (m_cnt == NR) begin
            m_ready = 1'b1;
            foreach (m_rf[i]) m_rf[i] = '0;
         end
      end else begin
         if (wb_en) begin
            if (wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            m_busy[wb_addr] = 1'b0;
         end
         if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
   endtask

   initial begin
      tbl[0]  = mk(1, 7, 32'hDEADBEEF, 0, 0,  1, 0,  32'h0, 0, 32'h0, 0);
      tbl[1]  = mk(1, 0, 32'h00001234, 0, 0,  7, 0,  32'hDEADBEEF, 0, 32'h0, 0);
      tbl[2]  = mk(0, 0, 32'h0,        1, 3,  0, 7,  32'h0, 0, 32'hDEADBEEF, 0);
      tbl[3]  = mk(0, 0, 32'h0,        1, 0,  3, 0,  32'h0, 1, 32'h0, 0);
      tbl[4]  = mk(1, 3, 32'h33,       1, 3,  0, 0,  32'h0, 0, 32'h0, 0);
      tbl[5]  = mk(0, 0, 32'h0,        0, 0,  3, 0,  32'h33, 1, 32'h0, 0);
      tbl[6]  = mk(1, 3, 32'h44,       0, 0,  0, 3,  32'h0, 0, BP ? 32'h44 : 32'h33, BP ? 0 : 1);
      tbl[7]  = mk(0, 0, 32'h0,        0, 0,  3, 0,  32'h44, 0, 32'h0, 0);
      tbl[8]  = mk(0, 0, 32'h0,        1, 9,  7, 0,  32'hDEADBEEF, 0, 32'h0, 0);
      tbl[9]  = mk(1, 9, 32'hA5A5A5A5, 0, 0,  7, 9,  32'hDEADBEEF, 0, BP ? 32'hA5A5A5A5 : 32'h0, BP ? 0 : 1);
      tbl[10] = mk(0, 0, 32'h0,        0, 0,  0, 9,  32'h0, 0, 32'hA5A5A5A5, 0);
      tbl[11] = mk(0, 0, 32'h0,        1, 12, 0, 0,  32'h0, 0, 32'h0, 0);
      tbl[12] = mk(1, 12, 32'h1212,    1, 13, 12, 13, BP ? 32'h1212 : 32'h0, BP ? 0 : 1, 32'h0, 0);
      tbl[13] = mk(0, 0, 32'h0,        0, 0,  12, 13, 32'h1212, 0, 32'h0, 1);

      rst_n = 1'b0;
      idle();
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      p_rs1_addr = '0; p_rs2_addr = '0; p_issue_valid = 1'b0; p_issue_rd = '0;
      p_wb_en = 1'b0; p_wb_addr = '0; p_wb_data = '0;
      m_ready = 1'b0; m_cnt = 0;
      cycle();
      cycle();

      // Clear sweep with a write to x5 that must be dropped.
      rst_n = 1'b1;
      for (int k = 0; k <= 32; k++) begin
         wb_en = (k < 32); wb_addr = 5'd5; wb_data = 32'hCAFE0005;
         issue_valid = (k < 32); issue_rd = 5'd5;
         #1;
         chk("sweep ready", 64'(ready), 64'(k >= 32));
         chk("sweep p_ready", 64'(p_ready), 64'(k >= 16));
         if (k < 32) chk("sweep rs1_data", 64'(rs1_data), 64'(0));
         check_all("sweep");
         cycle();
      end
      idle();
      #1;
      chk("x5 after sweep", 64'(rs1_data), 64'(0));
      chk("x5 busy after sweep", 64'(rs1_busy), 64'(0));

      for (int i = 0; i < 14; i++) begin
         wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
         issue_valid = tbl[i].iv; issue_rd = tbl[i].ir;
         rs1_addr = tbl[i].a1; rs2_addr = tbl[i].a2;
         #1;
         chk($sformatf("tbl%0d rs1_data", i), 64'(rs1_data), 64'(tbl[i].d1));
         chk($sformatf("tbl%0d rs1_busy", i), 64'(rs1_busy), 64'(tbl[i].b1));
         chk($sformatf("tbl%0d rs2_data", i), 64'(rs2_data), 64'(tbl[i].d2));
         chk($sformatf("tbl%0d rs2_busy", i), 64'(rs2_busy), 64'(tbl[i].b2));
         check_all($sformatf("tbl%0d model", i));
         cycle();
      end
      idle();

      // 64-bit / 16-entry instance.
      p_wb_en = 1'b1; p_wb_addr = 4'd15; p_wb_data = 64'hFFFF_0000_FFFF_0000;
      p_rs1_addr = 4'd15; p_rs2_addr = 4'd0;
      cycle();
      p_wb_en = 1'b0; p_rs2_addr = 4'd15;
      #1;
      chk("p x15 rs1", p_rs1_data, 64'hFFFF_0000_FFFF_0000);
      chk("p x15 rs2", p_rs2_data, 64'hFFFF_0000_FFFF_0000);
      chk("p x15 busy", 64'(p_rs1_busy), 64'(0));

      for (int n = 0; n < 300; n++) begin
         wb_en = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         issue_valid = 1'($urandom_range(0, 1)); issue_rd = 5'($urandom_range(0, 7));
         rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
         #1;
         check_all("rand");
         cycle();
      end
      idle();

      // Mid-run reset.
      issue_valid = 1'b1; issue_rd = 5'd4;
      cycle();
      issue_rd = 5'd5; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
      cycle();
      idle();
      rs1_addr = 5'd4; rs2_addr = 5'd5;
      #1;
      chk("pre-rst x4 busy", 64'(rs1_busy), 64'(1));
      chk("pre-rst x5 busy", 64'(rs2_busy), 64'(1));
      rs1_addr = 5'd6;
      #1;
      chk("pre-rst x6", 64'(rs1_data), 64'(32'h55));
      rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h99;
      issue_valid = 1'b1; issue_rd = 5'd7;
      cycle();
      rst_n = 1'b1;
      idle();
      rs1_addr = 5'd4; rs2_addr = 5'd5;
      for (int k = 0; k <= 32; k++) begin
         #1;
         chk("rerun ready", 64'(ready), 64'(k >= 32));
         check_all("rerun");
         cycle();
      end
      #1;
      chk("post-rst x4 busy", 64'(rs1_busy), 64'(0));
      chk("post-rst x5 busy", 64'(rs2_busy), 64'(0));
      rs1_addr = 5'd6; rs2_addr = 5'd7;
      #1;
      chk("post-rst x6", 64'(rs1_data), 64'(0));
      chk("post-rst x7 busy", 64'(rs2_busy), 64'(0));
      check_all("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RISC-V core: XLEN-wide, NREGS-deep, two combinational read ports and one synchronous write port.
- Register x0 is hardwired to zero.
- Adds two things the current file lacks:
  - a hardware clear sweep after reset, with a `ready` flag;
  - a per-register pending-write scoreboard for the hazard unit.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, ≥ 2.
- AW, $clog2(NREGS), address width; localparam, derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- ready  out  1  high once the clear sweep is done; block accepts traffic.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  register at rs1_addr has a pending write.
- rs2_busy  out  1  register at rs2_addr has a pending write.
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  AW  destination register of the issued instruction.
- wb_en  in  1  writeback strobe.
- wb_addr  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled at posedge clk).
  - Any posedge with rst_n=0 sets state=CLEAR, clr_cnt=0, ready=0, all scoreboard bits=0.
  - Register contents are not touched during reset.
- Reset mid-operation: same as above from any state.
  - Writeback or issue in the same cycle as reset is discarded.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each posedge with rst_n=1 writes rf[clr_cnt]<=0 and increments clr_cnt.
  - On the edge that clears entry NREGS-1: state<=RUN, ready<=1.
  - Therefore ready rises exactly NREGS edges after the first edge with rst_n high.
  - RUN: stays in RUN until the next reset.
- While ready=0:
  - wb_en and issue_valid are ignored.
  - rs*_data=0 and rs*_busy=0.
- Write (RUN only): if wb_en and wb_addr!=0, rf[wb_addr]<=wb_data at posedge. Write to x0 is dropped.
- Read: rsN_data = (rsN_addr==0) ? 0 : rf[rsN_addr]. Purely combinational, zero latency.
- Scoreboard (RUN only), bit busy[r]:
  - Set by issue_valid with issue_rd==r and r!=0.
  - Cleared by wb_en with wb_addr==r.
  - busy[0] is constant 0.
  - Simultaneous set and clear of the same r: the set wins (a new producer was issued), so busy stays 1.
  - Set and clear of different registers in the same cycle both take effect.
  - Writeback to a non-busy register: data is written, busy stays 0 (no error).
- rsN_busy = busy[rsN_addr], registered value. This is modified only by the bypass feature below.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding, applied per read port): if ready, wb_en, wb_addr==rsN_addr and rsN_addr!=0:
  - rsN_data=wb_data in the same cycle;
  - rsN_busy=0, unless issue_valid && issue_rd==rsN_addr in the same cycle.
- Undefined:
  - reads return the pre-write value during the writeback cycle;
  - busy deasserts the cycle after writeback;
  - the hazard unit must stall one extra cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default XLEN and NREGS constants;
  - state enum for the FSM (CLEAR, RUN);
  - reg-address typedef sized by AW.
- One natural sub-module: regfile_scoreboard_bits. It owns the NREGS-bit busy vector, the set/clear priority and the two busy read muxes.
- Storage, the clear FSM and the read muxes stay in the top module.

Test Plan:
- Clear sweep: hold rst_n=0 for 2 cycles, then release.
  - ready=0 for edges 1..31, ready=1 after edge 32.
  - All rs reads return 0.
  - A wb_en to x5 during the sweep is ignored: x5 reads 0 after ready.
- Write/read: write x7=0xDEADBEEF.
  - Next cycle rs1_addr=7 gives 0xDEADBEEF.
  - Write x0=0x1234: rs2_addr=0 reads 0.
- Scoreboard: issue x3, next cycle rs1_busy=1.
  - Writeback x3 with simultaneous issue x3: busy stays 1.
  - A later writeback x3 alone: busy=0 the following cycle.
  - Issue x0: busy never set.
- Bypass: same-cycle wb x9=0xA5A5A5A5 with rs2_addr=9.
  - With REGFILE_BYPASS_EN: rs2_data=0xA5A5A5A5, rs2_busy=0 the same cycle.
  - Without it: old value, and busy stays as registered.
- Mid-run reset: set busy on x4, x5, write x6=0x55, then pulse rst_n=0 for 1 cycle.
  - Busy bits all 0, ready=0 for 32 edges.
  - x6 reads 0 after ready.
- Parametrisation: NREGS=16, XLEN=64 instance.
  - ready after 16 edges.
  - 64-bit write/read of x15=0xFFFF_0000_FFFF_0000 is correct.
